uart_echo_fifo: RTL

//   Buffered echo controller between a uart core's RX and TX sides.

---
 rtl/uart_echo_fifo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// Buffered echo controller: captures bytes from a uart RX side on the falling
// edge of rx_busy, queues them in a small FIFO and replays them to the uart TX
// side one write strobe at a time, pacing on tx_busy. Also exposes the last
// byte, the fill level, a sticky overflow flag and a receive counter.
module uart_echo_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int MODE    = 0,
  parameter int BUSY_TO = 1023,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_busy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  output logic [DATA_W-1:0] last_rx,
  output logic [AW:0]       fifo_level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [15:0]       rx_count
);

  localparam int          TW         = $clog2(BUSY_TO + 1);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TO - 1);
  localparam bit          ECHO_EN    = (MODE != 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic                rx_busy_q;
  logic                cap;
  logic [DATA_W-1:0]   cap_data;
  logic                push;
  logic                pop;
  logic                drop;
  logic                start;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Optional lower-to-upper case mapping applied to every captured byte.
  function automatic logic [DATA_W-1:0] xf(input logic [DATA_W-1:0] d);
    if (MODE == 1 && d >= DATA_W'('h61) && d <= DATA_W'('h7A))
      xf = d - DATA_W'('h20);
    else
      xf = d;
  endfunction

  // One capture per falling edge of rx_busy.
  assign cap      = rx_busy_q & ~rx_busy;
  assign cap_data = xf(rx_data);

  // The pop happens in LOAD; a full FIFO still accepts a byte in that cycle.
  assign pop  = (state == LOAD);
  assign push = ECHO_EN && cap && ((fifo_level < LEVEL_FULL) || pop);
  assign drop = ECHO_EN && cap && !push;

  // A byte being pushed into an empty FIFO starts the transmitter right away,
  // so the strobe comes two cycles after the capture.
  assign start = ECHO_EN && ((fifo_level != '0) || push) && !tx_busy;

  // Edge detector, last byte and receive counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_busy_q <= 1'b0;
      last_rx   <= '0;
      rx_count  <= '0;
    end else begin
      rx_busy_q <= rx_busy;
      if (cap) begin
        last_rx  <= cap_data;
        rx_count <= rx_count + 16'd1;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cap_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  // TX sequencer: load, strobe, then wait for the uart to go busy and idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_data <= '0;
      tx_wr   <= 1'b0;
      timer   <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start)
            state <= LOAD;
        end
        LOAD: begin
          tx_data <= mem[rd_ptr];
          tx_wr   <= 1'b1;
          state   <= STROBE;
        end
        STROBE: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          // A uart that never answers costs us this byte, not the stream.
          if (tx_busy)
            state <= WAIT_LO;
          else if (timer == TIMER_LAST)
            state <= IDLE;
          else
            timer <= timer + 1'b1;
        end
        WAIT_LO: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
